// File: rtl/io_trap_pkg.sv
// Shared types and constants for the Z80 I/O trap block.
// Holds the FSM state encoding, control-register bit positions and default parameters.
package io_trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_HOLD = 2'd2
    } trap_state_e;

    localparam int CTRL_GUEST   = 0;
    localparam int CTRL_TRAP_EN = 1;
    localparam int CTRL_RSVD    = 2;

    localparam logic [7:0] DEFAULT_BASE_ADDR  = 8'h40;
    localparam int         DEFAULT_NMI_CYCLES = 4;

endpackage

// File: rtl/io_trap_nmi_pulse_gen.sv
// NMI pulse-width counter: loads the pulse length, counts down while enabled,
// and flags the last cycle of the pulse.
module nmi_pulse_gen #(
    parameter int NMI_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic count_i,
    output logic done_o
);

    logic [2:0] count_q;
    logic [2:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = 3'(NMI_CYCLES);
        end else if (count_i && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 3'd1);

endmodule

// File: rtl/io_trap.sv
// Guest-mode I/O trap for a Z80 system: decodes control/ISR port accesses and
// raises a fixed-width NMI when a guest executes I/O while trapping is enabled.
module io_trap
    import io_trap_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int         NMI_CYCLES = DEFAULT_NMI_CYCLES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [2:0] ctrl_in,
    output logic       write_ctrl_en,
    output logic       read_isr_en,
    output logic       record_isr_en,
    output logic       io_violation_occured,
    output logic       nmi_n,
    output logic       io_block_n
);

    localparam logic [7:0] ISR_ADDR = BASE_ADDR + 8'd1;

    trap_state_e state_q;
    trap_state_e state_d;
    logic        nmi_n_q;
    logic        nmi_n_d;
    logic        flag_q;
    logic        flag_d;
    logic        rd_n_q;
    logic        read_seen_q;

    logic io_cyc;
    logic guest;
    logic violation;
    logic cnt_load;
    logic cnt_run;
    logic cnt_done;
    logic flag_clear;
    logic unused_rsvd;

    // Interrupt acknowledge also drives IORQ low, but together with M1.
    assign io_cyc    = !iorq_n && m1_n;
    assign guest     = ctrl_in[CTRL_GUEST];
    assign violation = io_cyc && guest && ctrl_in[CTRL_TRAP_EN];

    assign unused_rsvd = ctrl_in[CTRL_RSVD];

    assign write_ctrl_en = io_cyc && !wr_n && (addr == BASE_ADDR) && !guest;
    assign read_isr_en   = io_cyc && !rd_n && (addr == ISR_ADDR) && !guest;
    assign record_isr_en = !m1_n && iorq_n && guest && (state_q != ST_TRAP);

    assign io_block_n = !(violation || ((state_q == ST_TRAP) && !iorq_n));

    nmi_pulse_gen #(
        .NMI_CYCLES(NMI_CYCLES)
    ) u_nmi_pulse_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (cnt_load),
        .count_i (cnt_run),
        .done_o  (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_run  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (violation) begin
                    state_d  = ST_TRAP;
                    cnt_load = 1'b1;
                end
            end
            ST_TRAP: begin
                cnt_run = 1'b1;
                if (cnt_done) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Wait for the trapping bus cycle to end so a held IORQ traps once.
                if (iorq_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-to-clear fires on the first edge that sees RD released after an ISR read.
    assign flag_clear = read_seen_q && rd_n && !rd_n_q;

    always_comb begin
        nmi_n_d = (state_d != ST_TRAP);
        flag_d  = flag_q;
        if (cnt_load) begin
            flag_d = 1'b1;
        end else if (flag_clear) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            nmi_n_q     <= 1'b1;
            flag_q      <= 1'b0;
            rd_n_q      <= 1'b1;
            read_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            nmi_n_q     <= nmi_n_d;
            flag_q      <= flag_d;
            rd_n_q      <= rd_n;
            read_seen_q <= read_isr_en;
        end
    end

    assign nmi_n                = nmi_n_q;
    assign io_violation_occured = flag_q;

endmodule

// File: tb/tb_io_trap.sv
// Randomized and directed bench for io_trap against a behavioural model of
// the trap timing, sticky flag and port decode.
module tb_io_trap;

    localparam logic [7:0] BASE = 8'h40;
    localparam int         NMI  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       iorq_n = 1'b1;
    logic       m1_n = 1'b1;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [2:0] ctrl_in = 3'b000;
    logic       write_ctrl_en;
    logic       read_isr_en;
    logic       record_isr_en;
    logic       io_violation_occured;
    logic       nmi_n;
    logic       io_block_n;

    int checks = 0;
    int failures = 0;
    int nmi_low_cnt = 0;

    // Model: cycles of NMI still to run, waiting-for-IORQ-release, sticky flag.
    int m_left = 0;
    bit m_wait = 1'b0;
    bit m_flag = 1'b0;
    bit m_prev_read = 1'b0;
    bit m_prev_rd = 1'b1;
    bit m_set;
    bit m_clr;

    io_trap #(.BASE_ADDR(BASE), .NMI_CYCLES(NMI)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .addr                 (addr),
        .iorq_n               (iorq_n),
        .m1_n                 (m1_n),
        .rd_n                 (rd_n),
        .wr_n                 (wr_n),
        .ctrl_in              (ctrl_in),
        .write_ctrl_en        (write_ctrl_en),
        .read_isr_en          (read_isr_en),
        .record_isr_en        (record_isr_en),
        .io_violation_occured (io_violation_occured),
        .nmi_n                (nmi_n),
        .io_block_n           (io_block_n)
    );

    always #5 clk = ~clk;

    function automatic bit f_io();
        return !iorq_n && m1_n;
    endfunction

    function automatic bit f_wr();
        return f_io() && !wr_n && (addr == BASE) && !ctrl_in[0];
    endfunction

    function automatic bit f_rd();
        return f_io() && !rd_n && (addr == BASE + 8'd1) && !ctrl_in[0];
    endfunction

    function automatic bit f_rec();
        return !m1_n && iorq_n && ctrl_in[0] && (m_left == 0);
    endfunction

    function automatic bit f_blk();
        return !((f_io() && ctrl_in[1:0] == 2'b11) || (m_left > 0 && !iorq_n));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_left      = 0;
            m_wait      = 1'b0;
            m_flag      = 1'b0;
            m_prev_read = 1'b0;
            m_prev_rd   = 1'b1;
        end else begin
            m_set = 1'b0;
            m_clr = m_prev_read && rd_n && !m_prev_rd;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_wait = 1'b1;
            end else if (m_wait) begin
                if (iorq_n) m_wait = 1'b0;
            end else if (f_io() && ctrl_in[1:0] == 2'b11) begin
                m_left = NMI;
                m_set  = 1'b1;
            end
            if (m_set) m_flag = 1'b1;
            else if (m_clr) m_flag = 1'b0;
            m_prev_read = f_rd();
            m_prev_rd   = rd_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("write_ctrl_en", 32'(write_ctrl_en), 32'(f_wr()));
        check("read_isr_en", 32'(read_isr_en), 32'(f_rd()));
        check("record_isr_en", 32'(record_isr_en), 32'(f_rec()));
        check("io_block_n", 32'(io_block_n), 32'(f_blk()));
        check("nmi_n", 32'(nmi_n), 32'(m_left == 0));
        check("flag", 32'(io_violation_occured), 32'(m_flag));
    endtask

    task automatic drive(input logic [2:0] c, input logic [7:0] a,
                         input logic io, input logic m1, input logic rd, input logic wr);
        @(negedge clk);
        ctrl_in = c;
        addr    = a;
        iorq_n  = io;
        m1_n    = m1;
        rd_n    = rd;
        wr_n    = wr;
        #1;
        check_all();
        if (!nmi_n) nmi_low_cnt++;
        $display("cyc ctrl=%b addr=%h iorq=%b m1=%b rd=%b wr=%b -> nmi_n=%b flag=%b blk=%b",
                 c, a, io, m1, rd, wr, nmi_n, io_violation_occured, io_block_n);
    endtask

    task automatic idle(input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) drive(c, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst_nmi_n", 32'(nmi_n), 32'd1);
        check("rst_flag", 32'(io_violation_occured), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset pulse applied");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_nmi_n", 32'(nmi_n), 32'd1);
        check("reset_flag", 32'(io_violation_occured), 32'd0);
        check("reset_io_block_n", 32'(io_block_n), 32'd1);
        reset_n = 1'b1;

        // Host writes the control port.
        drive(3'b000, BASE, 1'b0, 1'b1, 1'b1, 1'b0);
        check("host_wr_en", 32'(write_ctrl_en), 32'd1);
        drive(3'b000, BASE, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3'b000, 2);

        // Guest OUT traps: 4-cycle NMI.
        nmi_low_cnt = 0;
        for (int i = 0; i < 3; i++) drive(3'b011, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3'b011, 8);
        check("trap_nmi_width", 32'(nmi_low_cnt), 32'(NMI));
        check("trap_flag", 32'(io_violation_occured), 32'd1);

        // Host reads ISR, flag clears after RD release.
        for (int i = 0; i < 2; i++) drive(3'b000, BASE + 8'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("isr_rd_en", 32'(read_isr_en), 32'd1);
        idle(3'b000, 2);
        check("isr_clear", 32'(io_violation_occured), 32'd0);

        // Second OUT during the pulse does not retrigger.
        nmi_low_cnt = 0;
        for (int i = 0; i < 2; i++) drive(3'b011, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3'b011, 1);
        for (int i = 0; i < 2; i++) drive(3'b011, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3'b011, 10);
        check("no_retrigger_width", 32'(nmi_low_cnt), 32'(NMI));

        // Clear flag, then interrupt acknowledge must not trap.
        for (int i = 0; i < 2; i++) drive(3'b000, BASE + 8'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(3'b000, 2);
        nmi_low_cnt = 0;
        for (int i = 0; i < 3; i++) drive(3'b011, 8'hff, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(3'b011, 3);
        check("inta_no_nmi", 32'(nmi_low_cnt), 32'd0);
        check("inta_flag", 32'(io_violation_occured), 32'd0);

        // Reset in the 2nd cycle of TRAP.
        drive(3'b011, 8'h10, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(3'b011, 8'h10, 1'b1, 1'b1, 1'b1, 1'b1);
        check("pre_reset_trap", 32'(nmi_n), 32'd0);
        ctrl_in = 3'b000;
        reset_pulse();
        nmi_low_cnt = 0;
        idle(3'b000, 8);
        check("post_reset_no_nmi", 32'(nmi_low_cnt), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] c;
            logic [7:0] a;
            int sel;
            c   = ($urandom % 2 == 0) ? {1'($urandom % 2), 2'b11} : 3'($urandom % 8);
            sel = int'($urandom % 4);
            a   = (sel == 0) ? BASE : (sel == 1) ? BASE + 8'd1 : 8'($urandom);
            drive(c, a, 1'($urandom % 2), 1'($urandom % 4 != 0),
                  1'($urandom % 2), 1'($urandom % 2));
            if ($urandom % 150 == 0) reset_pulse();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_trap.md
IO_TRAP -- requirements
Module: io_trap

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'h40, the I/O port of the control register; BASE_ADDR+1 is the status/ISR port.
REQ-002 The block SHALL have parameter NMI_CYCLES, default 4, the NMI pulse width in clk cycles (range 1..7).
REQ-003 clk  input  1  Z80 system clock; all state updates on rising edge.
REQ-004 reset_n  input  1  Reset, asynchronous, active-low.
REQ-005 addr  input  8  Z80 A7..A0.
REQ-006 iorq_n, m1_n, rd_n, wr_n  input  1 each  Z80 bus strobes, active-low.
REQ-007 ctrl_in  input  3  Control register value; bit0 = guest mode, bit1 = trap enable, bit2 = reserved.
REQ-008 write_ctrl_en  output  1  Enable for the control register write.
REQ-009 read_isr_en  output  1  Enable for the status/ISR read.
REQ-010 record_isr_en  output  1  Enable for capturing the fetched opcode.
REQ-011 io_violation_occured  output  1  Sticky guest I/O violation flag.
REQ-012 nmi_n  output  1  NMI request to the Z80, active-low.
REQ-013 io_block_n  output  1  Low = suppress IORQ to external peripherals.

Function
REQ-014 io_cyc SHALL be defined as iorq_n=0 and m1_n=1; interrupt acknowledge (iorq_n=0, m1_n=0) SHALL NOT be treated as an I/O cycle.
REQ-015 write_ctrl_en SHALL be combinational: io_cyc, wr_n=0, addr=BASE_ADDR, ctrl_in[0]=0.
REQ-016 read_isr_en SHALL be combinational: io_cyc, rd_n=0, addr=BASE_ADDR+1, ctrl_in[0]=0.
REQ-017 record_isr_en SHALL be combinational: m1_n=0, iorq_n=1, ctrl_in[0]=1, FSM not in TRAP.
REQ-018 The FSM SHALL have states IDLE, TRAP, HOLD.
REQ-019 IDLE->TRAP on a rising clk edge sampling io_cyc with ctrl_in[1:0]=2'b11, any address including BASE_ADDR/BASE_ADDR+1.
REQ-020 On IDLE->TRAP, io_violation_occured SHALL set to 1 and the 3-bit NMI counter SHALL load NMI_CYCLES.
REQ-021 In TRAP: nmi_n=0; counter decrements each clk; at counter=1 the next state SHALL be HOLD.
REQ-022 In HOLD: nmi_n=1; HOLD->IDLE on the first clk edge sampling iorq_n=1.
REQ-023 io_block_n SHALL be 0 combinationally whenever io_cyc and ctrl_in[1:0]=2'b11, and also in TRAP while iorq_n=0; else 1.
REQ-024 io_violation_occured SHALL clear on the clk edge that samples rd_n=1 after a cycle with read_isr_en=1 (read-to-clear, registered rd_n edge detect).
REQ-025 Violation during TRAP or HOLD SHALL NOT retrigger the NMI or reload the counter; flag stays set.
REQ-026 Simultaneous set (REQ-020) and clear (REQ-024) on one edge: set SHALL win.
REQ-027 Clearing ctrl_in[0] or ctrl_in[1] mid-TRAP SHALL NOT shorten the NMI pulse.
REQ-028 A held iorq_n=0 SHALL produce exactly one trap (HOLD waits for release).

Reset
REQ-029 reset_n=0 SHALL immediately force FSM=IDLE, counter=0, io_violation_occured=0, nmi_n=1, rd_n edge register=1, regardless of clk.
REQ-030 Reset mid-TRAP SHALL terminate the NMI pulse asynchronously; no pulse SHALL resume after release.

Structure
REQ-031 A shared package SHALL hold FSM state encoding (2 bits), ctrl_in bit indices, and default BASE_ADDR/NMI_CYCLES constants.
REQ-032 The NMI pulse counter SHALL be a sub-module nmi_pulse_gen (load, count, done).
REQ-033 Enable decode (REQ-015..017) SHALL stay combinational in io_trap; outputs nmi_n and io_violation_occured SHALL be registered.

Verification
REQ-034 ctrl_in=3'b000, OUT (40h),05h -> write_ctrl_en=1 during wr_n low; nmi_n stays 1; io_block_n=1.
REQ-035 ctrl_in=3'b011, OUT (10h) -> flag=1, nmi_n low exactly 4 clks, io_block_n=0 during IORQ, FSM returns IDLE after iorq_n high.
REQ-036 ctrl_in=3'b011, second OUT 2 clks after the first trap -> no second pulse, total nmi_n low = 4 clks.
REQ-037 ctrl_in=3'b000 after trap, IN (41h) -> read_isr_en=1 during rd_n low; flag=0 on the edge after rd_n rises.
REQ-038 ctrl_in=3'b011, interrupt acknowledge (m1_n=0, iorq_n=0) -> no trap, flag 0, record_isr_en=0.
REQ-039 reset_n pulsed low in 2nd clk of TRAP -> nmi_n=1 immediately, flag=0, no NMI after release.
